// File: rtl/alu_seq_param_if.sv
// Request/result bundle between the register-read stage, the ALU and write-back.
interface alu_seq_param_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IMM_WIDTH = 7
);
    logic                 start;
    logic [2:0]           opcode;
    logic [WIDTH-1:0]     r2;
    logic [WIDTH-1:0]     r3;
    logic [IMM_WIDTH-1:0] entrada;
    logic                 flag_ram;
    logic [WIDTH-1:0]     saida;
    logic                 fimop;
    logic                 busy;
    logic                 zero;
    logic                 neg;
    logic                 ovf;
    logic                 err;

    modport master (
        output start, opcode, r2, r3, entrada, flag_ram,
        input  saida, fimop, busy, zero, neg, ovf, err
    );

    modport slave (
        input  start, opcode, r2, r3, entrada, flag_ram,
        output saida, fimop, busy, zero, neg, ovf, err
    );
endinterface

// File: rtl/alu_seq_param.sv
// Parametrised ALU stage: load/add/addi/sub/subi in one cycle, signed mul by
// iterative shift-add, status flags, optional saturation, start/fimop/flag_ram handshake.
module alu_seq_param #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IMM_WIDTH = 7,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_param_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SUBI = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

    logic [1:0]       state_q,  state_nx;
    logic [2:0]       op_q,     op_nx;
    logic [WIDTH-1:0] a_q,      a_nx;
    logic [WIDTH-1:0] b_q,      b_nx;
    logic [WIDTH-1:0] imm_q,    imm_nx;
    logic [PW-1:0]    acc_q,    acc_nx;
    logic [PW-1:0]    mcand_q,  mcand_nx;
    logic [WIDTH-1:0] mplier_q, mplier_nx;
    logic [CW-1:0]    cnt_q,    cnt_nx;
    logic [WIDTH-1:0] saida_q,  saida_nx;
    logic             fimop_q,  fimop_nx;
    logic             busy_q,   busy_nx;
    logic             zero_q,   zero_nx;
    logic             neg_q,    neg_nx;
    logic             ovf_q,    ovf_nx;
    logic             err_q,    err_nx;

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH:0]   a_w;
    logic [WIDTH:0]   b_w;
    logic [WIDTH:0]   imm_w;
    logic [WIDTH:0]   sum_c;
    logic [PW-1:0]    true_c;
    logic [WIDTH:0]   hi_c;
    logic             fits_c;
    logic [WIDTH-1:0] res_c;
    logic             legal_c;

    assign imm_ext = WIDTH'($signed(bus.entrada));

    // True (unclamped) result, overflow detection and saturation shared by EXEC and MUL.
    always_comb begin
        a_w   = {a_q[WIDTH-1], a_q};
        b_w   = {b_q[WIDTH-1], b_q};
        imm_w = {imm_q[WIDTH-1], imm_q};
        sum_c = '0;
        case (op_q)
            OP_LOAD: sum_c = imm_w;
            OP_ADD:  sum_c = a_w + b_w;
            OP_ADDI: sum_c = a_w + imm_w;
            OP_SUB:  sum_c = a_w - b_w;
            OP_SUBI: sum_c = a_w - imm_w;
            default: sum_c = '0;
        endcase
        legal_c = (op_q <= OP_MUL);
        true_c  = (state_q == S_MUL) ? acc_q : PW'($signed(sum_c));
        // Fits in WIDTH signed bits iff every bit from WIDTH-1 upward equals the sign.
        hi_c    = true_c[PW-1:WIDTH-1];
        fits_c  = (hi_c == '0) || (hi_c == '1);
        if (SATURATE && !fits_c) begin
            res_c = true_c[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_c = true_c[WIDTH-1:0];
        end
    end

    // Next-state, datapath and output-register inputs.
    always_comb begin
        state_nx  = state_q;
        op_nx     = op_q;
        a_nx      = a_q;
        b_nx      = b_q;
        imm_nx    = imm_q;
        acc_nx    = acc_q;
        mcand_nx  = mcand_q;
        mplier_nx = mplier_q;
        cnt_nx    = cnt_q;
        saida_nx  = saida_q;
        zero_nx   = zero_q;
        neg_nx    = neg_q;
        ovf_nx    = ovf_q;
        err_nx    = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_nx     = bus.opcode;
                    a_nx      = bus.r2;
                    b_nx      = bus.r3;
                    imm_nx    = imm_ext;
                    acc_nx    = '0;
                    mcand_nx  = PW'($signed(bus.r2));
                    mplier_nx = imm_ext;
                    cnt_nx    = '0;
                    state_nx  = (bus.opcode == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                if (legal_c) begin
                    saida_nx = res_c;
                    zero_nx  = (res_c == '0);
                    neg_nx   = res_c[WIDTH-1];
                    ovf_nx   = !fits_c;
                    err_nx   = 1'b0;
                end else begin
                    saida_nx = '0;
                    zero_nx  = 1'b1;
                    neg_nx   = 1'b0;
                    ovf_nx   = 1'b0;
                    err_nx   = 1'b1;
                end
                state_nx = S_DONE;
            end
            S_MUL: begin
                if (cnt_q == CW'(WIDTH)) begin
                    saida_nx = res_c;
                    zero_nx  = (res_c == '0);
                    neg_nx   = res_c[WIDTH-1];
                    ovf_nx   = !fits_c;
                    err_nx   = 1'b0;
                    state_nx = S_DONE;
                end else begin
                    // Multiplier MSB carries weight -2^(WIDTH-1): subtract on the last step.
                    if (mplier_q[0]) begin
                        acc_nx = (cnt_q == CW'(WIDTH - 1)) ? acc_q - mcand_q
                                                           : acc_q + mcand_q;
                    end
                    mcand_nx  = mcand_q << 1;
                    mplier_nx = mplier_q >> 1;
                    cnt_nx    = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.flag_ram) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        fimop_nx = (state_nx == S_DONE);
        busy_nx  = (state_nx != S_IDLE);
    end

    // State, datapath and registered outputs; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            saida_q  <= '0;
            fimop_q  <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_nx;
            op_q     <= op_nx;
            a_q      <= a_nx;
            b_q      <= b_nx;
            imm_q    <= imm_nx;
            acc_q    <= acc_nx;
            mcand_q  <= mcand_nx;
            mplier_q <= mplier_nx;
            cnt_q    <= cnt_nx;
            saida_q  <= saida_nx;
            fimop_q  <= fimop_nx;
            busy_q   <= busy_nx;
            zero_q   <= zero_nx;
            neg_q    <= neg_nx;
            ovf_q    <= ovf_nx;
            err_q    <= err_nx;
        end
    end

    assign bus.saida = saida_q;
    assign bus.fimop = fimop_q;
    assign bus.busy  = busy_q;
    assign bus.zero  = zero_q;
    assign bus.neg   = neg_q;
    assign bus.ovf   = ovf_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param: a wrapping and a saturating instance run in lockstep
// against directed vectors, handshake sequences and a randomized arithmetic model.
module tb_alu_seq_param;
    localparam int unsigned W  = 16;
    localparam int unsigned IW = 7;

    typedef struct {
        logic [W-1:0] saida;
        logic         zero;
        logic         neg;
        logic         ovf;
        logic         err;
    } res_t;

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [IW-1:0] imm;
        logic [W-1:0]  s_wrap;
        logic [W-1:0]  s_sat;
        logic          ovf;
        logic          err;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    alu_seq_param_if #(.WIDTH(W), .IMM_WIDTH(IW)) bw ();
    alu_seq_param_if #(.WIDTH(W), .IMM_WIDTH(IW)) bs ();

    assign bs.start    = bw.start;
    assign bs.opcode   = bw.opcode;
    assign bs.r2       = bw.r2;
    assign bs.r3       = bw.r3;
    assign bs.entrada  = bw.entrada;
    assign bs.flag_ram = bw.flag_ram;

    alu_seq_param #(.WIDTH(W), .IMM_WIDTH(IW), .SATURATE(1'b0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bw)
    );

    alu_seq_param #(.WIDTH(W), .IMM_WIDTH(IW), .SATURATE(1'b1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input string what, input longint act, input longint exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s/%s: got %0h expected %0h", tag, what, act, exp);
    endtask

    // Reference: exact integer arithmetic, then range check and clamp/wrap.
    function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [IW-1:0] imm, input bit sat);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint si = longint'($signed(imm));
        longint mx = (longint'(1) <<< (W - 1)) - 1;
        longint mn = -(longint'(1) <<< (W - 1));
        longint t;
        res_t   r;
        r.err = 1'b0;
        case (op)
            3'd0:    t = si;
            3'd1:    t = sa + sb;
            3'd2:    t = sa + si;
            3'd3:    t = sa - sb;
            3'd4:    t = sa - si;
            3'd5:    t = sa * si;
            default: begin t = 0; r.err = 1'b1; end
        endcase
        r.ovf = (t > mx) || (t < mn);
        if (sat && r.ovf) t = (t > 0) ? mx : mn;
        r.saida = W'(t);
        r.zero  = (r.saida == '0);
        r.neg   = r.saida[W-1];
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] s, input logic ovf, input logic err);
        res_t r;
        r.saida = s;
        r.zero  = (s == '0);
        r.neg   = s[W-1];
        r.ovf   = ovf;
        r.err   = err;
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return {1'b0, {(W-1){1'b1}}};
            1:       return {1'b1, {(W-1){1'b0}}};
            2:       return '0;
            3:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check_rst(input string tag);
        chk(tag, "saida_w", bw.saida, 0);  chk(tag, "saida_s", bs.saida, 0);
        chk(tag, "fimop_w", bw.fimop, 0);  chk(tag, "fimop_s", bs.fimop, 0);
        chk(tag, "busy_w",  bw.busy,  0);  chk(tag, "busy_s",  bs.busy,  0);
        chk(tag, "zero_w",  bw.zero,  0);  chk(tag, "neg_w",   bw.neg,   0);
        chk(tag, "ovf_w",   bw.ovf,   0);  chk(tag, "err_w",   bw.err,   0);
        chk(tag, "zero_s",  bs.zero,  0);  chk(tag, "ovf_s",   bs.ovf,   0);
    endtask

    task automatic do_ack(input string tag, input logic [W-1:0] sw, input logic [W-1:0] ss);
        @(negedge clk);
        bw.flag_ram = 1'b1;
        @(posedge clk); #1;
        bw.flag_ram = 1'b0;
        chk(tag, "ack_fimop_w", bw.fimop, 0);
        chk(tag, "ack_busy_w",  bw.busy,  0);
        chk(tag, "ack_fimop_s", bs.fimop, 0);
        chk(tag, "ack_saida_w", bw.saida, sw);
        chk(tag, "ack_saida_s", bs.saida, ss);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [IW-1:0] imm,
                          input res_t ew, input res_t es, input int exp_lat, input bit ack);
        int lat;
        @(negedge clk);
        bw.opcode  = op;
        bw.r2      = a;
        bw.r3      = b;
        bw.entrada = imm;
        bw.start   = 1'b1;
        @(posedge clk); #1;
        bw.start   = 1'b0;
        // Operands in flight must not depend on the live inputs.
        bw.opcode  = 3'($urandom);
        bw.r2      = W'($urandom);
        bw.r3      = W'($urandom);
        bw.entrada = IW'($urandom);
        chk(tag, "busy", bw.busy, 1);
        lat = 0;
        while (!bw.fimop && lat < 3 * W) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(tag, "latency", lat, exp_lat);
        chk(tag, "fimop_s", bs.fimop, 1);
        chk(tag, "saida_w", bw.saida, ew.saida); chk(tag, "saida_s", bs.saida, es.saida);
        chk(tag, "zero_w",  bw.zero,  ew.zero);  chk(tag, "zero_s",  bs.zero,  es.zero);
        chk(tag, "neg_w",   bw.neg,   ew.neg);   chk(tag, "neg_s",   bs.neg,   es.neg);
        chk(tag, "ovf_w",   bw.ovf,   ew.ovf);   chk(tag, "ovf_s",   bs.ovf,   es.ovf);
        chk(tag, "err_w",   bw.err,   ew.err);   chk(tag, "err_s",   bs.err,   es.err);
        if (ack) do_ack(tag, ew.saida, es.saida);
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{3'd0, 16'h0000, 16'h0000, 7'b1000000, 16'hFFC0, 16'hFFC0, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 16'h7FFF, 16'h0001, 7'h00,      16'h8000, 16'h7FFF, 1'b1, 1'b0};
        vecs[2]  = '{3'd3, 16'd5,    16'd5,    7'h00,      16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{3'd5, 16'd300,  16'h0000, 7'h7B,      16'hFA24, 16'hFA24, 1'b0, 1'b0};
        vecs[4]  = '{3'd5, 16'd1000, 16'h0000, 7'h3C,      16'hEA60, 16'h7FFF, 1'b1, 1'b0};
        vecs[5]  = '{3'd7, 16'h1234, 16'h5678, 7'h11,      16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[6]  = '{3'd4, 16'h8000, 16'h0000, 7'h01,      16'h7FFF, 16'h8000, 1'b1, 1'b0};
        vecs[7]  = '{3'd5, 16'h8000, 16'h0000, 7'h40,      16'h0000, 16'h7FFF, 1'b1, 1'b0};
        vecs[8]  = '{3'd2, 16'h0010, 16'h0000, 7'h7F,      16'h000F, 16'h000F, 1'b0, 1'b0};
        vecs[9]  = '{3'd5, 16'hFFF9, 16'h0000, 7'h00,      16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{3'd6, 16'h7FFF, 16'h7FFF, 7'h3F,      16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{3'd1, 16'h8000, 16'hFFFF, 7'h00,      16'h7FFF, 16'h8000, 1'b1, 1'b0};
        vecs[12] = '{3'd3, 16'h0000, 16'h8000, 7'h00,      16'h8000, 16'h7FFF, 1'b1, 1'b0};

        bw.start    = 1'b0;
        bw.flag_ram = 1'b0;
        bw.opcode   = '0;
        bw.r2       = '0;
        bw.r3       = '0;
        bw.entrada  = '0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_rst("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm,
                   mk(vecs[i].s_wrap, vecs[i].ovf, vecs[i].err),
                   mk(vecs[i].s_sat,  vecs[i].ovf, vecs[i].err),
                   (vecs[i].op == 3'd5) ? W + 1 : 1, 1'b1);
        end

        // DONE held without acknowledge; start pulses must be ignored.
        run_op("hold", 3'd1, 16'd2, 16'd3, 7'h00, mk(16'd5, 0, 0), mk(16'd5, 0, 0), 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bw.start  = (i % 2 == 0);
            bw.opcode = 3'd5;
            bw.r2     = W'($urandom);
            bw.r3     = W'($urandom);
            @(posedge clk); #1;
            chk("hold", "fimop", bw.fimop, 1);
            chk("hold", "busy",  bw.busy,  1);
            chk("hold", "saida_w", bw.saida, 5);
            chk("hold", "saida_s", bs.saida, 5);
        end

        // start with flag_ram in DONE: only ack, then accepted on the first IDLE edge.
        @(negedge clk);
        bw.start    = 1'b1;
        bw.flag_ram = 1'b1;
        bw.opcode   = 3'd1;
        bw.r2       = 16'd1;
        bw.r3       = 16'd1;
        @(posedge clk); #1;
        bw.flag_ram = 1'b0;
        chk("b2b", "fimop_ack", bw.fimop, 0);
        chk("b2b", "busy_ack",  bw.busy,  0);
        chk("b2b", "saida_ack", bw.saida, 5);
        @(posedge clk); #1;
        bw.start = 1'b0;
        chk("b2b", "busy_acc",  bw.busy,  1);
        chk("b2b", "fimop_acc", bw.fimop, 0);
        @(posedge clk); #1;
        chk("b2b", "fimop", bw.fimop, 1);
        chk("b2b", "saida_w", bw.saida, 2);
        chk("b2b", "saida_s", bs.saida, 2);
        do_ack("b2b", 16'd2, 16'd2);

        // Reset during the eighth multiplier iteration.
        @(negedge clk);
        bw.opcode  = 3'd5;
        bw.r2      = 16'd300;
        bw.entrada = 7'h7B;
        bw.start   = 1'b1;
        @(posedge clk); #1;
        bw.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mulrst", "busy_pre", bw.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_rst("mulrst");
        @(negedge clk);
        rst = 1'b0;
        run_op("postrst", 3'd1, 16'd2, 16'd3, 7'h00, mk(16'h0005, 0, 0), mk(16'h0005, 0, 0), 1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]    op;
            logic [W-1:0]  a;
            logic [W-1:0]  b;
            logic [IW-1:0] imm;
            op  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            imm = IW'($urandom);
            run_op($sformatf("rnd%0d", i), op, a, b, imm, model(op, a, b, imm, 1'b0),
                   model(op, a, b, imm, 1'b1), (op == 3'd5) ? W + 1 : 1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Parametrised successor to the Mini_cpu ALU stage. It executes load/add/addi/sub/subi/mul on signed operands of configurable width. It uses an explicit start/fimop/flag_ram handshake, a multi-cycle iterative multiplier, status flags and optional saturation. It sits between the register-file read stage and the RAM/register write-back stage; write-back acknowledges each result with flag_ram.

Parameters:
WIDTH, 16, data width of r2, r3 and saida (>= 4)
IMM_WIDTH, 7, width of immediate entrada; MSB is sign (2..WIDTH)
SATURATE, 0, 1 = clamp overflowing results to signed max/min; 0 = wrap modulo 2^WIDTH

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
opcode  in  3  000 load, 001 add, 010 addi, 011 sub, 100 subi, 101 mul, 110/111 illegal
r2  in  WIDTH  operand A (signed)
r3  in  WIDTH  operand B (signed)
entrada  in  IMM_WIDTH  immediate, sign-extended to WIDTH
flag_ram  in  1  write-back acknowledge of current result
saida  out  WIDTH  registered result
fimop  out  1  result valid; high for the whole DONE state
busy  out  1  high in EXEC, MUL and DONE
zero  out  1  saida == 0
neg  out  1  saida MSB
ovf  out  1  signed overflow of the true result, independent of SATURATE
err  out  1  illegal opcode

Behaviour:
- Reset (rst high at an edge, in any state, including mid-multiply): state IDLE; saida=0; fimop=busy=zero=neg=ovf=err=0; multiplier accumulator and counter cleared. Reset has priority over all other inputs.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - start=1 at an edge latches opcode, r2, r3 and sign-extended entrada (imm). This edge is the acceptance edge k.
  - Next state is MUL if opcode=101, otherwise EXEC.
  - flag_ram is ignored.
- EXEC, one cycle: at edge k+1, register saida and flags; go to DONE.
  - load: imm. add: r2+r3. addi: r2+imm. sub: r2-r3. subi: r2-imm.
  - Sums and differences are computed at WIDTH+1 bits.
  - ovf=1 when the true result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - load never overflows.
  - Illegal opcode: saida=0, err=1, ovf=0.
- MUL: signed r2*imm via iterative shift-add, one multiplier bit per cycle.
  - Exactly WIDTH iteration edges: k+1..k+WIDTH.
  - At edge k+WIDTH+1, register saida and flags; go to DONE.
  - The result must equal the exact 2*WIDTH-bit signed product, truncated or saturated.
  - ovf=1 when the product does not fit WIDTH signed bits.
- Output selection: SATURATE=1 and ovf=1 gives saida=2^(WIDTH-1)-1 for positive true results and -2^(WIDTH-1) for negative ones. Otherwise saida is the low WIDTH bits of the true result.
- Flags: zero and neg are computed from the final saida (after saturation). err=0 for legal opcodes.
- DONE:
  - fimop=1; saida and all flags are held stable.
  - flag_ram=1 at an edge: IDLE, fimop=0, busy=0 after that edge. saida and flags keep their last value until the next result.
  - flag_ram=0: remain in DONE indefinitely.
- Latency from acceptance edge k to fimop high: 1 cycle (EXEC ops) and WIDTH+1 cycles (mul). Exactly one result per accepted start.
- start while busy=1 is ignored; it is neither queued nor stored.
- start and flag_ram both high in DONE: only the acknowledge takes effect. A start held high is then accepted at the first edge in IDLE, so the minimum back-to-back spacing is DONE→IDLE→accept.
- Operand inputs may change after acceptance without affecting the result in flight.

Test Plan:
- Reset state: assert rst for 2 cycles → saida=0x0000, fimop=0, busy=0, zero=neg=ovf=err=0.
- load (WIDTH=16): start with opcode=000, entrada=7'b1000000 → fimop high 1 cycle after acceptance, saida=0xFFC0, neg=1, ovf=0; flag_ram=1 → IDLE, fimop=0 next cycle.
- add overflow: r2=0x7FFF, r3=0x0001:
  - SATURATE=0 → saida=0x8000, ovf=1, neg=1.
  - SATURATE=1 → saida=0x7FFF, ovf=1, neg=0.
- sub to zero: r2=5, r3=5, sub → saida=0x0000, zero=1, ovf=0.
- mul: r2=300, entrada=-5 → saida=0xFA24 (-1500), fimop exactly 17 cycles after acceptance.
  - r2=1000, entrada=60 → ovf=1; saida=0xEA60 (SATURATE=0) or 0x7FFF (SATURATE=1).
- Handshake and robustness:
  - Hold flag_ram=0 for 5 cycles in DONE, pulsing start with new operands → saida and fimop stable, no new operation.
  - opcode=111 → err=1, saida=0.
  - rst at iteration 8 of a mul → all outputs reset next cycle; a following add 2+3 returns 0x0005.
